// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size encodings, FSM state
// enum and small address helpers used at request handshake.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4
  } mau_state_e;

  // A halfword must sit on an even address; a word (or size 11) on a
  // multiple of four. Bytes are always aligned.
  function automatic logic mau_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Clears the address bits that would make the access misaligned.
  function automatic logic [31:0] mau_align(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] a;
    case (size)
      SZ_BYTE: a = addr;
      SZ_HALF: a = {addr[31:1], 1'b0};
      default: a = {addr[31:2], 2'b00};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mau_lane_mux.sv
// Byte-lane steering for the memory access unit: extracts and extends the
// addressed lane of a read word, and merges store data into a read word.
module mau_lane_mux
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word[{lane, 3'b000} +: 8];
  assign half_s = lane[1] ? word[31:16] : word[15:0];

  // Select the extended load value and the merged store word by size.
  always_comb begin
    ext_data = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        ext_data = {{24{is_signed & byte_s[7]}}, byte_s};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ext_data = {{16{is_signed & half_s[15]}}, half_s};
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      default: begin
        ext_data = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-addressed data memory.
// Sub-word stores use a read-modify-write sequence.
// Optional: define MAU_MISALIGN_TRAP_EN to report misaligned accesses via
// resp_err instead of silently aligning the address.
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  mau_state_e  state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] merge_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        write_r;
  logic        err_pend_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;

  logic        hs_s;
  logic        misalign_s;
  logic [31:0] addr_in_s;
  logic [31:0] ext_s;
  logic [31:0] merged_s;
  logic        re_s;
  logic        we_s;
  logic [31:0] wd_s;

  assign req_ready = (state_r == ST_IDLE) & ~rst;
  assign hs_s      = req_valid & req_ready;

`ifdef MAU_MISALIGN_TRAP_EN
  assign misalign_s = mau_misaligned(req_size, req_addr[1:0]);
  assign addr_in_s  = req_addr;
`else
  assign misalign_s = 1'b0;
  assign addr_in_s  = mau_align(req_size, req_addr);
`endif

  mau_lane_mux u_lane_mux (
    .size      (size_r),
    .is_signed (signed_r),
    .lane      (addr_r[1:0]),
    .word      (mem_rdata),
    .wdata     (wdata_r),
    .ext_data  (ext_s),
    .merged    (merged_s)
  );

  // Decode memory strobes and write data from the current state.
  always_comb begin
    re_s = 1'b0;
    we_s = 1'b0;
    wd_s = 32'd0;
    case (state_r)
      ST_LOAD:   re_s = 1'b1;
      ST_STORE:  begin we_s = 1'b1; wd_s = wdata_r; end
      ST_RMW_RD: re_s = 1'b1;
      ST_RMW_WR: begin we_s = 1'b1; wd_s = merge_r; end
      default:   begin re_s = 1'b0; we_s = 1'b0; end
    endcase
  end

  assign mem_re     = re_s;
  assign mem_we     = we_s;
  assign mem_wdata  = wd_s;
  assign mem_addr   = (re_s | we_s) ? {2'b00, addr_r[31:2]} : 32'd0;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

  // Request capture, FSM sequencing and registered response generation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      merge_r      <= 32'd0;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      write_r      <= 1'b0;
      err_pend_r   <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      err_pend_r   <= 1'b0;
      // A misaligned request answers one cycle after it was accepted.
      if (err_pend_r) begin
        resp_valid_r <= 1'b1;
        resp_err_r   <= 1'b1;
        resp_rdata_r <= 32'd0;
      end else begin
        resp_rdata_r <= resp_rdata_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            addr_r   <= addr_in_s;
            wdata_r  <= req_wdata;
            size_r   <= req_size;
            signed_r <= req_signed;
            write_r  <= req_write;
            if (misalign_s) begin
              err_pend_r <= 1'b1;
              state_r    <= ST_IDLE;
            end else if (!req_write) begin
              state_r <= ST_LOAD;
            end else if ((req_size == SZ_BYTE) || (req_size == SZ_HALF)) begin
              state_r <= ST_RMW_RD;
            end else begin
              state_r <= ST_STORE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= write_r ? 32'd0 : ext_s;
          state_r      <= ST_IDLE;
        end
        ST_STORE: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= 32'd0;
          state_r      <= ST_IDLE;
        end
        ST_RMW_RD: begin
          merge_r <= merged_s;
          state_r <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= 32'd0;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a 64-word memory model and a
// byte-level reference model of loads and stores.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bd_en = 1'b0;
  logic [5:0]  bd_addr = 6'd0;
  logic [31:0] bd_data = 32'd0;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, re_cnt = 0, both_cnt = 0, resp_cnt = 0;

`ifdef MAU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];

  // Memory: backdoor preload or DUT synchronous write.
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
  end

  // Activity counters sampled on every rising edge.
  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input int nb, input bit sg);
    logic [63:0] v, m;
    v = {32'd0, word} >> (8 * off);
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input int off, input int nb, input logic [31:0] wd);
    logic [63:0] m, r;
    m = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
    r = ({32'd0, word} & ~m) | (({32'd0, wd} << (8 * off)) & m);
    return r[31:0];
  endfunction

  // Backdoor write of one memory word and its reference copy (call at negedge).
  task automatic poke(input int w, input logic [31:0] d);
    bd_en = 1'b1; bd_addr = w[5:0]; bd_data = d;
    ref_mem[w] = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  // Issue one request at a negedge; return at the negedge of the response cycle.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int we_d, output int re_d);
    int we0, re0, guard;
    we0 = we_cnt; re0 = re_cnt; guard = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = 2'($urandom);
    req_signed = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 8) begin @(negedge clk); lat++; end
    if (!resp_valid) lat = 99;
    rd = resp_rdata; er = resp_err;
    we_d = we_cnt - we0; re_d = re_cnt - re0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_addr = $urandom; req_size = 2'b10; req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs got ready=%b rv=%b we=%b re=%b want all 0", req_ready, resp_valid, mem_we, mem_re);
      end
    end
    checks++;
    if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp got rdata=%h err=%b want 0/0", resp_rdata, resp_err);
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_load_extend();
    int lat, wd, rdn; logic [31:0] rd; logic er;
    poke(4, 32'h80FF_1234);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, lat, rd, er, wd, rdn);
    checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lb_latency got %0d want 2", lat); end
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, lat, rd, er, wd, rdn);
    checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", rd); end
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, lat, rd, er, wd, rdn);
    checks++; if (rd !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_data got %h want ffff80ff", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, lat, rd, er, wd, rdn);
    checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL lhu_data got %h want 00001234", rd); end
  endtask

  task automatic test_subword_store();
    int lat, wd, rdn; logic [31:0] rd; logic er;
    @(negedge clk);
    poke(2, 32'h1122_3344);
    do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_BEEF, lat, rd, er, wd, rdn);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency got %0d want 3", lat); end
    checks++; if (mem[2] !== 32'hBEEF_3344) begin errors++; $display("FAIL sh_mem got %h want beef3344", mem[2]); end
    checks++; if (wd !== 1 || rdn !== 1) begin errors++; $display("FAIL sh_accesses got we=%0d re=%0d want 1/1", wd, rdn); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL sh_rdata got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, wd, rdn; logic [31:0] rd; logic er;
    @(negedge clk);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, lat, rd, er, wd, rdn);
    checks++; if (wd !== 1 || lat !== 2) begin errors++; $display("FAIL sw_we got we=%0d lat=%0d want 1/2", wd, lat); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, lat, rd, er, wd, rdn);
    checks++; if (rd !== 32'hDEAD_BEEF || lat !== 2) begin errors++; $display("FAIL b2b_lw got %h lat=%0d want deadbeef lat=2", rd, lat); end
  endtask

  task automatic test_misaligned();
    int lat, wd, rdn; logic [31:0] rd; logic er;
    @(negedge clk);
    poke(1, 32'hCAFE_F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'd0, lat, rd, er, wd, rdn);
`ifdef MAU_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1 || lat !== 2) begin errors++; $display("FAIL mis_err got err=%b lat=%0d want 1/2", er, lat); end
    checks++; if (wd !== 0 || rdn !== 0) begin errors++; $display("FAIL mis_noaccess got we=%0d re=%0d want 0/0", wd, rdn); end
`else
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL mis_align got %h err=%b want cafef00d/0", rd, er); end
    checks++; if (rdn !== 1 || lat !== 2) begin errors++; $display("FAIL mis_access got re=%0d lat=%0d want 1/2", rdn, lat); end
`endif
  endtask

  task automatic test_reset_mid_rmw();
    int we0, r0;
    @(negedge clk);
    poke(3, 32'hA5A5_5A5A);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0D; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL rmw_rd_state got re=%b want 1", mem_re); end
    rst = 1'b1; we0 = we_cnt; r0 = resp_cnt;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (we_cnt !== we0 || resp_cnt !== r0 || mem[3] !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL rst_abandon got we=%0d resp=%0d mem=%h want %0d %0d a5a55a5a", we_cnt, resp_cnt, mem[3], we0, r0);
    end
  endtask

  task automatic test_random();
    int lat, wd, rdn, nb, off, exp_lat;
    logic [31:0] rd, a, ea, d;
    logic er, w, sg, mis;
    logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 1); sz = 2'($urandom); sg = $urandom_range(0, 1);
      a = $urandom_range(0, 255); d = $urandom;
      nb = nbytes(sz);
      mis = TRAP && ((a % nb) != 0);
      ea = TRAP ? a : (a - (a % nb));
      off = ea % 4;
      exp_lat = (mis || !w || nb == 4) ? 2 : 3;
      do_req(w, sz, sg, a, d, lat, rd, er, wd, rdn);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency #%0d got %0d want %0d", i, lat, exp_lat); end
      checks++; if (er !== mis) begin errors++; $display("FAIL rnd_err #%0d got %b want %b", i, er, mis); end
      if (!mis) begin
        if (!w) begin
          checks++;
          if (rd !== ref_load(ref_mem[ea >> 2], off, nb, sg)) begin
            errors++; $display("FAIL rnd_load #%0d got %h want %h", i, rd, ref_load(ref_mem[ea >> 2], off, nb, sg));
          end
        end else begin
          ref_mem[ea >> 2] = ref_store(ref_mem[ea >> 2], off, nb, d);
          checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rnd_store_rdata #%0d got %h want 0", i, rd); end
        end
        checks++;
        if (mem[ea >> 2] !== ref_mem[ea >> 2]) begin
          errors++; $display("FAIL rnd_mem #%0d got %h want %h", i, mem[ea >> 2], ref_mem[ea >> 2]);
        end
      end else begin
        checks++; if (wd !== 0 || rdn !== 0) begin errors++; $display("FAIL rnd_mis_access #%0d got we=%0d re=%0d want 0/0", i, wd, rdn); end
      end
      if ((i % 3) == 0) begin
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rnd_pulse #%0d got %b want 0", i, resp_valid); end
      end
    end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL re_we_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    test_reset();
    for (int k = 0; k < 64; k++) poke(k, $urandom);
    test_load_extend();
    test_subword_store();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_rmw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
